// File: rtl/tempo_pkg.sv
// rtl/tempo_pkg.sv - shared types and widths for the tempo controller
package tempo_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNT_IN = 2'd1,
        RUN      = 2'd2
    } state_t;

    localparam int ACC_W = 34;
    localparam int BPM_W = 8;
    localparam int IDX_W = 3;

endpackage

// File: rtl/tempo_ctrl_phase_acc_tick.sv
// rtl/tempo_ctrl_phase_acc_tick.sv - modulo-LIMIT phase accumulator with beat tick
module phase_acc_tick #(
    parameter int               ACC_W = 34,
    parameter int               INC_W = 8,
    parameter logic [ACC_W-1:0] LIMIT = ACC_W'(64'd6000000000)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [INC_W-1:0] inc,
    output logic             tick
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;

    // Subtracting LIMIT instead of zeroing keeps the remainder, so the beat rate has no drift.
    always_comb begin
        sum  = acc + ACC_W'(inc);
        tick = en && (sum >= LIMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= tick ? (sum - LIMIT) : sum;
        end
    end

endmodule

// File: rtl/tempo_ctrl.sv
// rtl/tempo_ctrl.sv - metronome: tempo buttons, count-in sequencing, beat and bar enables
module tempo_ctrl
    import tempo_pkg::*;
#(
    parameter int CLK_HZ        = 100000000,
    parameter int BPM_MIN       = 40,
    parameter int BPM_MAX       = 240,
    parameter int BPM_DEFAULT   = 120,
    parameter int BPM_STEP      = 4,
    parameter int BEATS_PER_BAR = 4
) (
    input  logic             clk_100M,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_start,
    output logic [BPM_W-1:0] bpm,
    output logic             running,
    output logic             count_in,
    output logic             beat_tick,
    output logic             bar_tick,
    output logic [IDX_W-1:0] beat_idx
);

    localparam logic [ACC_W-1:0] LIMIT    = ACC_W'(64'(CLK_HZ) * 64'd60);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS_PER_BAR - 1);

    state_t           state, state_d;
    logic             up_q, down_q, start_q;
    logic             up_press, down_press, start_press;
    logic [BPM_W-1:0] bpm_d;
    logic [BPM_W:0]   bpm_up;
    logic [IDX_W-1:0] idx_d;
    logic             beat_d, bar_d, acc_clr, acc_tick;

    assign up_press    = btn_up & ~up_q;
    assign down_press  = btn_down & ~down_q;
    assign start_press = btn_start & ~start_q;

    assign running  = (state != IDLE);
    assign count_in = (state == COUNT_IN);

    phase_acc_tick #(
        .ACC_W (ACC_W),
        .INC_W (BPM_W),
        .LIMIT (LIMIT)
    ) u_phase (
        .clk   (clk_100M),
        .rst_n (rst_n),
        .en    (running),
        .clr   (acc_clr),
        .inc   (bpm),
        .tick  (acc_tick)
    );

    // Simultaneous up and down cancel out.
    always_comb begin
        bpm_up = {1'b0, bpm} + {1'b0, BPM_W'(BPM_STEP)};
        bpm_d  = bpm;
        if (up_press && !down_press) begin
            bpm_d = (bpm_up > {1'b0, BPM_W'(BPM_MAX)}) ? BPM_W'(BPM_MAX) : bpm_up[BPM_W-1:0];
        end else if (down_press && !up_press) begin
            bpm_d = (bpm < BPM_W'(BPM_MIN + BPM_STEP)) ? BPM_W'(BPM_MIN) : bpm - BPM_W'(BPM_STEP);
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = beat_idx;
        beat_d  = 1'b0;
        bar_d   = 1'b0;
        acc_clr = 1'b0;
        case (state)
            IDLE: begin
                if (start_press) begin
                    state_d = COUNT_IN;
                    idx_d   = '0;
                    beat_d  = 1'b1;
                    bar_d   = 1'b1;
                    acc_clr = 1'b1;
                end
            end
            COUNT_IN, RUN: begin
                // Stop takes priority over a beat landing in the same cycle.
                if (start_press) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    acc_clr = 1'b1;
                end else if (acc_tick) begin
                    beat_d = 1'b1;
                    if (beat_idx == LAST_IDX) begin
                        idx_d   = '0;
                        bar_d   = 1'b1;
                        state_d = RUN;
                    end else begin
                        idx_d = beat_idx + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100M) begin
        if (!rst_n) begin
            state     <= IDLE;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            start_q   <= 1'b0;
            bpm       <= BPM_W'(BPM_DEFAULT);
            beat_idx  <= '0;
            beat_tick <= 1'b0;
            bar_tick  <= 1'b0;
        end else begin
            state     <= state_d;
            up_q      <= btn_up;
            down_q    <= btn_down;
            start_q   <= btn_start;
            bpm       <= bpm_d;
            beat_idx  <= idx_d;
            beat_tick <= beat_d;
            bar_tick  <= bar_d;
        end
    end

endmodule

// File: tb/tb_tempo_ctrl.sv
// tb/tb_tempo_ctrl.sv - randomized and directed bench for tempo_ctrl against a behavioural model
module tb_tempo_ctrl;

    localparam longint LIMIT = 60000;
    localparam int     BPB   = 4;

    logic       clk;
    logic       rst_n;
    logic       btn_up, btn_down, btn_start;
    logic [7:0] bpm;
    logic       running, count_in, beat_tick, bar_tick;
    logic [2:0] beat_idx;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int last_beat = 0;
    int prev_beat = 0;
    bit chk = 0;

    // behavioural model state
    int     m_bpm, m_mode, m_idx;
    longint m_acc;
    bit     m_beat, m_bar, pu, pd, ps;

    tempo_ctrl #(
        .CLK_HZ        (1000),
        .BPM_MIN       (40),
        .BPM_MAX       (240),
        .BPM_DEFAULT   (120),
        .BPM_STEP      (4),
        .BEATS_PER_BAR (BPB)
    ) dut (
        .clk_100M  (clk),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_start (btn_start),
        .bpm       (bpm),
        .running   (running),
        .count_in  (count_in),
        .beat_tick (beat_tick),
        .bar_tick  (bar_tick),
        .beat_idx  (beat_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // mode: 0 idle, 1 count-in, 2 run
    always @(posedge clk) begin
        bit up, dn, st;
        if (!rst_n) begin
            m_bpm = 120; m_mode = 0; m_idx = 0; m_acc = 0;
            m_beat = 0; m_bar = 0; pu = 0; pd = 0; ps = 0;
        end else begin
            up = btn_up && !pu;
            dn = btn_down && !pd;
            st = btn_start && !ps;
            pu = btn_up; pd = btn_down; ps = btn_start;
            m_beat = 0;
            m_bar  = 0;
            if (st) begin
                if (m_mode == 0) begin
                    m_mode = 1; m_beat = 1; m_bar = 1;
                end else begin
                    m_mode = 0;
                end
                m_acc = 0;
                m_idx = 0;
            end else if (m_mode != 0) begin
                m_acc = m_acc + m_bpm;
                if (m_acc >= LIMIT) begin
                    m_acc  = m_acc - LIMIT;
                    m_beat = 1;
                    m_idx  = (m_idx + 1) % BPB;
                    if (m_idx == 0) begin
                        m_bar  = 1;
                        m_mode = 2;
                    end
                end
            end
            if (up && !dn) m_bpm = (m_bpm + 4 > 240) ? 240 : m_bpm + 4;
            else if (dn && !up) m_bpm = (m_bpm - 4 < 40) ? 40 : m_bpm - 4;
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            tests++;
            if (bpm !== 8'(m_bpm) || running !== (m_mode != 0) || count_in !== (m_mode == 1) ||
                beat_tick !== m_beat || bar_tick !== m_bar || beat_idx !== 3'(m_idx)) begin
                failed++;
                $display("FAIL model_cmp cyc=%0d: bpm %0d/%0d run %b/%b cin %b/%b beat %b/%b bar %b/%b idx %0d/%0d (got/expected)",
                         cyc, bpm, m_bpm, running, m_mode != 0, count_in, m_mode == 1,
                         beat_tick, m_beat, bar_tick, m_bar, beat_idx, m_idx);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_beat(input int budget);
        int n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (beat_tick === 1'b1) begin
                prev_beat = last_beat;
                last_beat = cyc;
                return;
            end
        end
        check("beat_timeout", 0, 1);
    endtask

    task automatic press(input int which);
        case (which)
            0: btn_up = 1'b1;
            1: btn_down = 1'b1;
            2: btn_start = 1'b1;
            default: begin btn_up = 1'b1; btn_down = 1'b1; end
        endcase
        @(negedge clk);
        btn_up = 1'b0; btn_down = 1'b0; btn_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        btn_up = 0; btn_down = 0; btn_start = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk = 1;
        check("reset_bpm", bpm, 120);
        check("reset_running", running, 0);
        check("reset_idx", beat_idx, 0);
        check("reset_beat", beat_tick, 0);
        rst_n = 1;
        repeat (3) @(negedge clk);

        // count-in from 120 BPM: downbeat one cycle after the press, then every 500 cycles
        btn_start = 1;
        n = cyc;
        @(negedge clk);
        btn_start = 0;
        check("s1_down_beat", beat_tick, 1);
        check("s1_down_bar", bar_tick, 1);
        check("s1_down_cin", count_in, 1);
        check("s1_down_lat", cyc - n, 1);
        last_beat = cyc;
        for (int k = 1; k <= 4; k++) begin
            wait_beat(1000);
            check("s1_period", last_beat - prev_beat, 500);
            check("s1_idx", beat_idx, k % 4);
        end
        check("s1_run_cin", count_in, 0);
        check("s1_run_running", running, 1);
        check("s1_run_bar", bar_tick, 1);

        // tempo ramp 120->240 in 30 presses starting 190 cycles after a beat
        repeat (189) @(negedge clk);
        for (int i = 0; i < 30; i++) press(0);
        check("s3_bpm", bpm, 240);
        wait_beat(1000);
        check("s3_phase_interval", last_beat - prev_beat, 360);
        wait_beat(1000);
        check("s3_interval_240", last_beat - prev_beat, 250);

        press(2);
        check("s3_stop", running, 0);
        do_reset();
        @(negedge clk);

        // saturation
        for (int i = 0; i < 40; i++) press(0);
        check("s2_sat_max", bpm, 240);
        for (int i = 0; i < 60; i++) press(1);
        check("s2_sat_min", bpm, 40);
        for (int i = 0; i < 15; i++) press(0);
        check("s2_bpm_100", bpm, 100);
        press(3);
        check("s2_both", bpm, 100);

        // 10000 cycles of RUN at 100 BPM
        press(2);
        for (int k = 0; k < 4; k++) wait_beat(1000);
        check("s4_in_run", count_in, 0);
        n = 0;
        begin
            int bad_idx = 0;
            for (int i = 0; i < 10000; i++) begin
                @(negedge clk);
                if (beat_tick === 1'b1) begin
                    n++;
                    if (beat_idx !== 3'(n % 4)) bad_idx++;
                end
            end
            check("s4_beats", n, 16);
            check("s4_idx_seq", bad_idx, 0);
        end

        // stop in RUN, restart, stop at count-in beat 2
        btn_start = 1; @(negedge clk); btn_start = 0;
        check("s5_stop_run", running, 0);
        @(negedge clk);
        press(2);
        wait_beat(1000);
        wait_beat(1000);
        check("s5_cin_idx2", beat_idx, 2);
        btn_start = 1; @(negedge clk); btn_start = 0;
        check("s5_stop_cin_running", running, 0);
        check("s5_stop_cin_idx", beat_idx, 0);
        @(negedge clk);

        // stop coincident with a RUN beat
        press(2);
        for (int k = 0; k < 4; k++) wait_beat(1000);
        repeat (599) @(negedge clk);
        btn_start = 1; @(negedge clk); btn_start = 0;
        check("s5_coinc_beat", beat_tick, 0);
        check("s5_coinc_running", running, 0);
        check("s5_coinc_idx", beat_idx, 0);
        @(negedge clk);

        // reset mid-RUN
        press(2);
        for (int k = 0; k < 5; k++) wait_beat(1000);
        repeat (100) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        check("s6_bpm", bpm, 120);
        check("s6_running", running, 0);
        check("s6_beat", beat_tick, 0);
        check("s6_idx", beat_idx, 0);
        n = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (beat_tick === 1'b1) n++;
        end
        check("s6_no_ticks", n, 0);

        // random button traffic, checked cycle by cycle against the model
        for (int i = 0; i < 5000; i++) begin
            btn_up    = ($urandom_range(0, 39) == 0);
            btn_down  = ($urandom_range(0, 39) == 0);
            btn_start = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        btn_up = 0; btn_down = 0; btn_start = 0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/tempo_ctrl.md
Name: tempo_ctrl

Overview:
Metronome/tempo controller for the piano datapath. It holds a user-adjustable tempo in BPM and generates exact-rate beat and bar enable pulses in the clk_100M domain, using a phase accumulator instead of fixed divide-by-N counters. It sequences a one-bar count-in before free-running beats, with start/stop and tempo up/down driven from debounced buttons. Downstream note, LED and 7-segment logic consume its single-cycle enables.

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz
BPM_MIN, 40, lowest tempo (saturation floor)
BPM_MAX, 240, highest tempo (saturation ceiling, at most 255)
BPM_DEFAULT, 120, tempo loaded at reset
BPM_STEP, 4, increment/decrement per button press
BEATS_PER_BAR, 4, beats per bar, 2..8

Ports:
clk_100M  in  1  system clock
rst_n  in  1  synchronous active-low reset
btn_up  in  1  debounced level, tempo up
btn_down  in  1  debounced level, tempo down
btn_start  in  1  debounced level, start/stop toggle
bpm  out  8  current tempo
running  out  1  high in COUNT_IN or RUN
count_in  out  1  high in COUNT_IN only
beat_tick  out  1  one-cycle pulse per beat
bar_tick  out  1  one-cycle pulse coincident with beat_tick when beat_idx==0
beat_idx  out  3  beat within bar, 0..BEATS_PER_BAR-1

Behaviour:
- Clock and reset: single clock clk_100M; reset is synchronous, active-low (rst_n), sampled on the rising edge of clk_100M.
- Reset values: bpm=BPM_DEFAULT, running=0, count_in=0, beat_tick=0, bar_tick=0, beat_idx=0, accumulator=0, state=IDLE, button history regs=0.
- Edge detect: each btn_* is registered once; press = btn & ~btn_q. The press is acted on at the same edge at which btn_q updates. All outputs are registered.
- Tempo: a press on up adds BPM_STEP and saturates at BPM_MAX; a press on down subtracts BPM_STEP and saturates at BPM_MIN. Up and down pressed in the same cycle: no change. A tempo change applies to the next accumulator add. The accumulator is not cleared and beat phase is preserved.
- Accumulator: LIMIT = CLK_HZ*60 (6e9, 33-bit constant). acc width = 34 bits. Each cycle in COUNT_IN/RUN, sum = acc + bpm. If sum >= LIMIT, then acc <= sum - LIMIT and a beat fires; else acc <= sum. The long-run rate is exact, with no cumulative drift. acc holds 0 in IDLE.
- FSM states: IDLE, COUNT_IN, RUN.
  - IDLE + start press -> COUNT_IN. Next cycle: beat_tick=1, bar_tick=1, beat_idx=0, acc=0 (immediate downbeat).
  - COUNT_IN: on each beat, beat_idx increments. When the beat with beat_idx wrapping from BEATS_PER_BAR-1 back to 0 fires -> RUN. That beat pulses bar_tick and has count_in=0.
  - RUN: beats continue; beat_idx wraps at BEATS_PER_BAR-1 -> 0 with bar_tick.
  - COUNT_IN or RUN + start press -> IDLE. The same cycle forces beat_tick=0, beat_idx=0, acc=0. A start press wins over a coincident beat.
- beat_tick/bar_tick are never high for two consecutive cycles. This is guaranteed because bpm < LIMIT.
- Reset mid-operation (COUNT_IN/RUN) returns to reset values on the next edge; no pulse is emitted.
- A start press in the same cycle as up/down: both are processed.

Decomposition:
- Shared package tempo_pkg:
  - state enum (IDLE, COUNT_IN, RUN)
  - LIMIT width constant ACC_W=34
  - BPM_W=8
  - beat-index width constant
- Natural sub-module: phase_acc_tick, holding the accumulator, compare/subtract, clear input, and tick output; parameterised on LIMIT and widths.
- Edge detect and saturation stay in the top.

Test Plan:
All scenarios use CLK_HZ=1000, so LIMIT=60000.
1. Reset, then press start at 120 BPM -> beat_tick is high 1 cycle after the press with bar_tick=1 and count_in=1. Subsequent beats come every 500 cycles. After 4 beats: count_in=0, running=1, bar_tick pulses with beat_idx=0.
2. Press up 40 times from 120 -> bpm stops at 240. Press down 60 times -> bpm stops at 40. Up and down together -> bpm unchanged.
3. RUN at 120 BPM; 250 cycles after a beat, set bpm to 240 -> next beat is 125 cycles later (acc carries 30000). The phase result is checked against the exact model.
4. BPM=100 (period 600) in RUN for 10000 cycles -> exactly 16 beat_ticks with correct beat_idx sequence 0,1,2,3,0,... and no drift versus the reference model.
5. Press start during COUNT_IN beat 2, and again in the same cycle as a beat in RUN -> IDLE next cycle; beat_tick=0, beat_idx=0, running=0.
6. Assert rst_n=0 mid-RUN for 1 cycle -> all outputs return to reset values and bpm=120. No tick appears until the next start press.
